// File: rtl/typing_pkg.sv
// ============================================================================
// Module : typing_pkg
// Brief  : Shared types and BCD helper for the typing game controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package typing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  // One BCD digit step: returns {carry_out, next_digit}; 9 rolls to 0 with carry.
  function automatic logic [4:0] bcd_inc_sat(input bcd_digit_t d, input logic cin);
    if (!cin) begin
      return {1'b0, d};
    end else if (d >= 4'd9) begin
      return {1'b1, 4'd0};
    end else begin
      return {1'b0, d + 4'd1};
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/typing_game_ctrl_bcd_sat_counter.sv
// ============================================================================
// Module : bcd_sat_counter
// Brief  : N-digit BCD counter with clear and increment; holds at all-9s.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_sat_counter
  import typing_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    inc,
  output logic [0:DIGITS-1][3:0]  count
);

  logic [0:DIGITS-1][3:0] w_next;
  logic                   w_all_nine;

  always_comb begin
    logic w_carry;
    w_carry    = 1'b1;
    w_next     = count;
    w_all_nine = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      {w_carry, w_next[i]} = bcd_inc_sat(count[i], w_carry);
      if (count[i] != 4'd9) w_all_nine = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !w_all_nine) begin
      count <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/typing_game_ctrl.sv
// ============================================================================
// Module : typing_game_ctrl
// Brief  : Typing game FSM, keystroke scoring and countdown control.
//          Optional miss counter enabled by TYPING_MISS_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module typing_game_ctrl
  import typing_pkg::*;
#(
  parameter int KEY_W        = 8,
  parameter int SCORE_DIGITS = 4,
  parameter int MISS_DIGITS  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          key_valid,
  input  logic [KEY_W-1:0]              key_code,
  input  logic [KEY_W-1:0]              target_code,
  input  logic                          min_finish,
  output logic                          timer_reset,
  output logic                          target_advance,
  output logic [1:0]                    game_state,
  output logic [0:SCORE_DIGITS-1][3:0]  score_bcd,
  output logic [0:MISS_DIGITS-1][3:0]   miss_bcd
);

  game_state_t r_state;
  game_state_t w_state_next;
  logic        w_key_hit;
  logic        w_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = ARMED;
      ARMED:   w_state_next = RUN;
      RUN:     if (min_finish) w_state_next = DONE;
      DONE:    if (start) w_state_next = ARMED;
      default: w_state_next = IDLE;
    endcase
  end

  assign game_state = r_state;
  assign w_key_hit  = (r_state == RUN) && key_valid && (key_code == target_code);
  // Clearing on entry to ARMED makes the counts read zero while ARMED is visible.
  assign w_clear    = (w_state_next == ARMED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_reset    <= 1'b1;
      target_advance <= 1'b0;
    end else begin
      timer_reset    <= (w_state_next != RUN);
      target_advance <= w_key_hit;
    end
  end

  bcd_sat_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .inc   (w_key_hit),
    .count (score_bcd)
  );

`ifdef TYPING_MISS_COUNT_EN
  logic w_key_miss;
  assign w_key_miss = (r_state == RUN) && key_valid && (key_code != target_code);

  bcd_sat_counter #(.DIGITS(MISS_DIGITS)) u_miss (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .inc   (w_key_miss),
    .count (miss_bcd)
  );
`else
  assign miss_bcd = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_typing_game_ctrl.sv
// ============================================================================
// Module : tb_typing_game_ctrl
// Brief  : Self-checking bench for typing_game_ctrl (table, directed, random).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_typing_game_ctrl;

`ifdef TYPING_MISS_COUNT_EN
  localparam int MISS_ON = 1;
`else
  localparam int MISS_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             key_valid;
  logic [7:0]       key_code;
  logic [7:0]       target_code;
  logic             min_finish;
  logic             timer_reset;
  logic             target_advance;
  logic [1:0]       game_state;
  logic [0:3][3:0]  score_bcd;
  logic [0:2][3:0]  miss_bcd;

  typing_game_ctrl #(.KEY_W(8), .SCORE_DIGITS(4), .MISS_DIGITS(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .target_code    (target_code),
    .min_finish     (min_finish),
    .timer_reset    (timer_reset),
    .target_advance (target_advance),
    .game_state     (game_state),
    .score_bcd      (score_bcd),
    .miss_bcd       (miss_bcd)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;

  // Reference model: plain integers, state numbered as on the game_state port.
  int m_st, m_score, m_miss;
  bit m_adv;

  function automatic logic [15:0] to_bcd4(input int v);
    logic [0:3][3:0] d;
    for (int i = 0; i < 4; i++) d[i] = 4'((v / (10 ** i)) % 10);
    return d;
  endfunction

  function automatic logic [11:0] to_bcd3(input int v);
    logic [0:2][3:0] d;
    for (int i = 0; i < 3; i++) d[i] = 4'((v / (10 ** i)) % 10);
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_score = 0; m_miss = 0; m_adv = 0;
  endtask

  task automatic model_step(input bit st, input bit kv, input logic [7:0] k,
                            input logic [7:0] t, input bit mf);
    m_adv = 0;
    case (m_st)
      0: if (st) m_st = 1;
      1: m_st = 2;
      2: begin
        if (kv) begin
          if (k == t) begin
            m_adv = 1;
            if (m_score < 9999) m_score++;
          end else if (MISS_ON != 0 && m_miss < 999) begin
            m_miss++;
          end
        end
        if (mf) m_st = 3;
      end
      default: if (st) m_st = 1;
    endcase
    if (m_st == 1) begin
      m_score = 0;
      m_miss  = 0;
    end
  endtask

  task automatic check_model();
    chk("state", 32'(game_state), 32'(m_st));
    chk("timer_reset", 32'(timer_reset), 32'(m_st != 2));
    chk("target_advance", 32'(target_advance), 32'(m_adv));
    chk("score", 32'(score_bcd), 32'(to_bcd4(m_score)));
    chk("miss", 32'(miss_bcd), 32'(to_bcd3(m_miss)));
  endtask

  task automatic step(input bit st, input bit kv, input logic [7:0] k,
                      input logic [7:0] t, input bit mf);
    @(negedge clk);
    start = st; key_valid = kv; key_code = k; target_code = t; min_finish = mf;
    @(posedge clk);
    model_step(st, kv, k, t, mf);
    #1;
    check_model();
  endtask

  typedef struct {
    bit         start;
    bit         kv;
    logic [7:0] key;
    logic [7:0] tgt;
    bit         mf;
    int         st;
    bit         tr;
    bit         adv;
    int         score;
    int         miss;
  } vec_t;

  vec_t vecs[10];
  bit   prev_kv;

  initial begin
    vecs[0] = '{1, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0};
    vecs[1] = '{0, 0, 8'h00, 8'h00, 0, 2, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 8'h41, 8'h41, 0, 2, 0, 1, 1, 0};
    vecs[3] = '{0, 0, 8'h00, 8'h42, 0, 2, 0, 0, 1, 0};
    vecs[4] = '{0, 1, 8'h42, 8'h43, 0, 2, 0, 0, 1, MISS_ON};
    vecs[5] = '{1, 0, 8'h00, 8'h43, 0, 2, 0, 0, 1, MISS_ON};
    vecs[6] = '{0, 1, 8'h41, 8'h41, 1, 3, 1, 1, 2, MISS_ON};
    vecs[7] = '{0, 1, 8'h41, 8'h41, 0, 3, 1, 0, 2, MISS_ON};
    vecs[8] = '{1, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0};
    vecs[9] = '{0, 0, 8'h00, 8'h00, 0, 2, 0, 0, 0, 0};

    reset = 1'b1; start = 0; key_valid = 0; key_code = 0; target_code = 0; min_finish = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 8'h00, 0);

    // Directed table: arm, run, hit, miss, finish with key, ignored key, re-arm
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].start, vecs[i].kv, vecs[i].key, vecs[i].tgt, vecs[i].mf);
      chk($sformatf("vec%0d_state", i), 32'(game_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_tr", i), 32'(timer_reset), 32'(vecs[i].tr));
      chk($sformatf("vec%0d_adv", i), 32'(target_advance), 32'(vecs[i].adv));
      chk($sformatf("vec%0d_score", i), 32'(score_bcd), 32'(to_bcd4(vecs[i].score)));
      chk($sformatf("vec%0d_miss", i), 32'(miss_bcd), 32'(to_bcd3(vecs[i].miss)));
    end

    // BCD carry 0009 -> 0010
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 8'h55, 8'h55, 0);
      step(0, 0, 8'h00, 8'h00, 0);
    end
    chk("score_9", 32'(score_bcd), 32'h9000);
    step(0, 1, 8'h55, 8'h55, 0);
    chk("score_10", 32'(score_bcd), 32'h0100);
    step(0, 0, 8'h00, 8'h00, 0);

    // Fill to 9999, then saturate
    for (int i = 10; i < 9999; i++) begin
      step(0, 1, 8'h30, 8'h30, 0);
      step(0, 0, 8'h00, 8'h00, 0);
    end
    chk("score_9999", 32'(score_bcd), 32'h9999);
    step(0, 1, 8'h31, 8'h31, 0);
    chk("sat_score", 32'(score_bcd), 32'h9999);
    chk("sat_adv", 32'(target_advance), 32'd1);
    step(0, 0, 8'h00, 8'h00, 0);

    // Wrong keys: counted only with the miss counter built in
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h61, 8'h62, 0);
      chk("wrong_adv", 32'(target_advance), 32'd0);
      step(0, 0, 8'h00, 8'h00, 0);
    end
    chk("wrong_miss", 32'(miss_bcd), 32'(to_bcd3(5 * MISS_ON)));
    chk("wrong_score", 32'(score_bcd), 32'h9999);

    step(0, 0, 8'h00, 8'h00, 1);
    chk("finish_state", 32'(game_state), 32'd3);

    // Randomized traffic against the model
    prev_kv = 0;
    for (int i = 0; i < 600; i++) begin
      bit st, kv, mf;
      logic [7:0] k, t;
      st = ($urandom_range(0, 19) == 0);
      mf = ($urandom_range(0, 24) == 0);
      kv = !prev_kv && ($urandom_range(0, 1) == 1);
      k  = 8'($urandom_range(8'h41, 8'h43));
      t  = 8'($urandom_range(8'h41, 8'h43));
      step(st, kv, k, t, mf);
      prev_kv = kv;
    end
    step(0, 0, 8'h00, 8'h00, 0);

    // Reach RUN with a nonzero score, then reset asynchronously
    step(1, 0, 8'h00, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 0);
    step(0, 1, 8'h41, 8'h41, 0);
    chk("pre_reset_state", 32'(game_state), 32'd2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_state", 32'(game_state), 32'd0);
    chk("async_tr", 32'(timer_reset), 32'd1);
    chk("async_adv", 32'(target_advance), 32'd0);
    chk("async_score", 32'(score_bcd), 32'd0);
    chk("async_miss", 32'(miss_bcd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
